// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared states, default timing and counter sizing for the PLL reset sequencer
package pll_rst_pkg;

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    SETTLE,
    RUN
  } pll_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 5000;
  localparam int DEF_CNT_W         = 8;

  // The shared timer only ever has to reach (largest period - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for one asynchronous level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset/lock sequencer gating the system reset request
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst_req,
  input  logic             pll_locked,
  input  logic             pll_activeclk,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             running,
  output logic             active_ref,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] switch_count
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  pll_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             locked_s, act_s, act_q;
  logic             pll_rst_q, sys_rst_q, running_q;
  logic [CNT_W-1:0] retry_q, loss_q, switch_q;
  logic             retry_inc, loss_inc, switch_inc;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk), .rst (rst), .d_i (pll_locked), .q_o (locked_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_act (
    .clk (clk), .rst (rst), .d_i (pll_activeclk), .q_o (act_s)
  );

  always_comb begin
    state_d    = state_q;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    switch_inc = 1'b0;
    if (soft_rst_req) begin
      state_d = RST_PLL;
    end else begin
      case (state_q)
        RST_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = SETTLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = RST_PLL;
            retry_inc = 1'b1;
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Loss of lock keeps the PLL running; a persistent loss escalates via the WAIT_LOCK timeout.
          if (!locked_s) begin
            state_d  = WAIT_LOCK;
            loss_inc = 1'b1;
          end else if (act_s != act_q) begin
            state_d    = SETTLE;
            switch_inc = 1'b1;
          end
        end
        default: state_d = RST_PLL;
      endcase
    end

    // A held soft request re-enters RST_PLL every cycle, so it restarts the timer too.
    if (state_d != state_q || soft_rst_req) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_PLL;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
      switch_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_s;
      pll_rst_q <= (state_d == RST_PLL);
      sys_rst_q <= (state_d != RUN);
      running_q <= (state_d == RUN);
      if (retry_inc && retry_q != '1) retry_q <= retry_q + CNT_W'(1);
      if (loss_inc && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
      if (switch_inc && switch_q != '1) switch_q <= switch_q + CNT_W'(1);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign running         = running_q;
  assign active_ref      = act_s;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign switch_count    = switch_q;

endmodule
